// File: rtl/cla_adder_registered.sv
// Two-level carry-lookahead adder with a registered result stage.
// Bit carries and block carries are both expanded in flattened AND-OR form.
module cla_adder_registered #(
    parameter int WIDTH      = 32,
    parameter int BLOCK_SIZE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
);

    localparam int NB = (WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int PW = NB * BLOCK_SIZE;

    logic [PW-1:0]    gx, px, c;
    logic [NB-1:0]    gg, pp;
    logic [NB:0]      cb;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, valid_q;

    // Bit generate/propagate, padded so a narrow top block passes carries through.
    always_comb begin
        gx = '0;
        px = '1;
        gx[WIDTH-1:0] = A & B;
        px[WIDTH-1:0] = A ^ B;
    end

    // Group generate and propagate per block.
    always_comb begin
        logic t;
        gg = '0;
        pp = '1;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                pp[b] = pp[b] & px[b*BLOCK_SIZE+j];
                t = gx[b*BLOCK_SIZE+j];
                for (int m = j + 1; m < BLOCK_SIZE; m++)
                    t = t & px[b*BLOCK_SIZE+m];
                gg[b] = gg[b] | t;
            end
        end
    end

    // Second-level lookahead: every block carry-in as a sum of products.
    always_comb begin
        logic t;
        cb = '0;
        cb[0] = Cin;
        for (int k = 0; k < NB; k++) begin
            t = Cin;
            for (int m = 0; m <= k; m++)
                t = t & pp[m];
            cb[k+1] = t;
            for (int i = 0; i <= k; i++) begin
                t = gg[i];
                for (int m = i + 1; m <= k; m++)
                    t = t & pp[m];
                cb[k+1] = cb[k+1] | t;
            end
        end
    end

    // In-block lookahead: each bit carry straight from the block carry-in.
    always_comb begin
        logic t;
        c = '0;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                t = cb[b];
                for (int m = 0; m < j; m++)
                    t = t & px[b*BLOCK_SIZE+m];
                c[b*BLOCK_SIZE+j] = t;
                for (int i = 0; i < j; i++) begin
                    t = gx[b*BLOCK_SIZE+i];
                    for (int m = i + 1; m < j; m++)
                        t = t & px[b*BLOCK_SIZE+m];
                    c[b*BLOCK_SIZE+j] = c[b*BLOCK_SIZE+j] | t;
                end
            end
        end
    end

    assign sum_d  = px[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign cout_d = cb[NB];

    // Capture result on valid input; hold data otherwise, valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
            valid_q <= in_valid;
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_cla_adder_registered.sv
// Directed and random checks for cla_adder_registered,
// at 32/4 and 30/4 (partial top block).
module tb_cla_adder_registered;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b, sum;
    logic        cin, iv, cout, ov;
    logic [29:0] a2, b2, sum2;
    logic        cin2, iv2, cout2, ov2;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    cla_adder_registered #(.WIDTH(32), .BLOCK_SIZE(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .Cin(cin),
        .in_valid(iv), .Sum(sum), .Cout(cout), .out_valid(ov)
    );

    cla_adder_registered #(.WIDTH(30), .BLOCK_SIZE(4)) dut30 (
        .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Cin(cin2),
        .in_valid(iv2), .Sum(sum2), .Cout(cout2), .out_valid(ov2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        iv = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ov, cout, sum} !== 34'h0)
            $display("FAIL reset_async: got ov=%b cout=%b sum=%h want 0/0/0",
                     ov, cout, sum);
        else passed++;
        step();
        step();
        total++;
        if ({ov, cout, sum} !== 34'h0)
            $display("FAIL reset_hold: got ov=%b cout=%b sum=%h want 0/0/0",
                     ov, cout, sum);
        else passed++;
        total++;
        if ({ov2, cout2, sum2} !== 32'h0)
            $display("FAIL reset_w30: got ov=%b cout=%b sum=%h want 0/0/0",
                     ov2, cout2, sum2);
        else passed++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F};
        logic [31:0] vb [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000001};
        logic        vc [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [32:0] ve [4] = '{33'h000000001, 33'h100000000,
                                33'h1FFFFFFFF, 33'h000000010};
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i]; iv = 1'b1;
            step();
            total++;
            if ({cout, sum} !== ve[i] || ov !== 1'b1)
                $display("FAIL directed_%0d: got ov=%b %h want ov=1 %h",
                         i, ov, {cout, sum}, ve[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp;
        int          bad = 0;
        iv = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + 33'(cin);
            step();
            total++;
            if ({cout, sum} !== exp || ov !== 1'b1) begin
                $display("FAIL random_%0d: got ov=%b %h want ov=1 %h",
                         i, ov, {cout, sum}, exp);
                bad++;
            end else passed++;
        end
        iv = 1'b0;
    endtask

    task automatic test_partial_block();
        logic [30:0] exp;
        logic [29:0] da [2] = '{30'h3FFFFFFF, 30'h3C000000};
        logic [29:0] db [2] = '{30'h0, 30'h04000000};
        logic        dc [2] = '{1'b1, 1'b0};
        logic [30:0] de [2] = '{31'h40000000, 31'h40000000};
        iv2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a2 = da[i]; b2 = db[i]; cin2 = dc[i];
            step();
            total++;
            if ({cout2, sum2} !== de[i] || ov2 !== 1'b1)
                $display("FAIL w30_directed_%0d: got ov=%b %h want ov=1 %h",
                         i, ov2, {cout2, sum2}, de[i]);
            else passed++;
        end
        for (int i = 0; i < 22; i++) begin
            a2 = 30'($urandom); b2 = 30'($urandom);
            cin2 = 1'($urandom_range(0, 1));
            exp = {1'b0, a2} + {1'b0, b2} + 31'(cin2);
            step();
            total++;
            if ({cout2, sum2} !== exp || ov2 !== 1'b1)
                $display("FAIL w30_random_%0d: got ov=%b %h want ov=1 %h",
                         i, ov2, {cout2, sum2}, exp);
            else passed++;
        end
        iv2 = 1'b0;
    endtask

    task automatic test_valid_gating();
        a = 32'd5; b = 32'd7; cin = 1'b0; iv = 1'b1;
        step();
        total++;
        if (sum !== 32'd12 || cout !== 1'b0 || ov !== 1'b1)
            $display("FAIL gate_load: got ov=%b cout=%b sum=%h want 1/0/0000000c",
                     ov, cout, sum);
        else passed++;
        a = 32'd1; b = 32'd1; iv = 1'b0;
        step();
        total++;
        if (sum !== 32'd12 || cout !== 1'b0 || ov !== 1'b0)
            $display("FAIL gate_hold: got ov=%b cout=%b sum=%h want 0/0/0000000c",
                     ov, cout, sum);
        else passed++;
        step();
        total++;
        if (sum !== 32'd12 || ov !== 1'b0)
            $display("FAIL gate_hold2: got ov=%b sum=%h want 0/0000000c",
                     ov, sum);
        else passed++;
    endtask

    task automatic test_reset_midop();
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; iv = 1'b1;
        #3 rst_n = 1'b0;
        step();
        total++;
        if ({ov, cout, sum} !== 34'h0)
            $display("FAIL midop_discard: got ov=%b cout=%b sum=%h want 0/0/0",
                     ov, cout, sum);
        else passed++;
        rst_n = 1'b1;
        step();
        total++;
        if (sum !== 32'h23456789 || cout !== 1'b0 || ov !== 1'b1)
            $display("FAIL midop_first: got ov=%b cout=%b sum=%h want 1/0/23456789",
                     ov, cout, sum);
        else passed++;
        iv = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; iv = 1'b0;
        a2 = '0; b2 = '0; cin2 = 1'b0; iv2 = 1'b0;
        #12;
        test_reset();
        test_directed();
        test_back_to_back();
        test_partial_block();
        test_valid_gating();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
